ahb2apb_bridge: RTL and testbench
=================================

# ahb2apb_bridge

AHB-lite slave to APB master bridge. It is the DUT stage driven by the AHB master agent: it accepts single AHB transfers selected by `HSELAPBif` and re-issues each one as an APB SETUP/ACCESS sequence to one of up to four peripherals. It inserts AHB wait states until the APB access completes, and returns an ERROR response for unmapped or oversized transfers.

## Interface
Parameters:
- `BASE_NIB`, default 4'h8: required value of `HADDR[31:28]` for a mapped access.
- `NSLV`, default 4 (range 1..4): number of APB slaves. Slot = `HADDR[27:26]`.

Ports:
- `HCLK` in 1: the only clock; all logic on its rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `HSELAPBif` in 1: bridge select.
- `HTRANs` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HWRITE` in 1: 1 = write.
- `HREADYin` in 1: bus ready; an address phase is valid only when this is high.
- `HADDR` in 32: address.
- `HSIZE` in 3: transfer size.
- `HWDATA` in 32: write data, valid in the cycle after the address phase.
- `HREADYout` out 1: 0 = wait state.
- `HRESP` out 2: 00 OKAY, 01 ERROR.
- `HRDATA` out 32: read data.
- `PSEL` out NSLV: one-hot slave select.
- `PENABLE` out 1: ACCESS phase indicator.
- `PWRITE` out 1: APB direction.
- `PADDR` out 32: APB address.
- `PWDATA` out 32: APB write data.
- `PRDATA` in 32: APB read data.
- `PREADY` in 1: APB completion; present only under `AHB2APB_PREADY_EN`.

## Operation
- Valid transfer = `HSELAPBif & HREADYin & HTRANs[1]`. It is sampled only in IDLE, or in the completing cycle of ACCESS or ERR2.
- IDLE/BUSY transfers, or `HSELAPBif=0`: no action; bridge stays in IDLE and answers OKAY with zero wait.
- Decode at the sampling edge. A transfer is mapped if `HADDR[31:28]==BASE_NIB`, `HADDR[27:26]<NSLV` and `HSIZE<=3'b010`. Anything else goes to ERR1.
- FSM states: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: on a mapped write go to WWAIT; on a mapped read go to SETUP; on an unmapped transfer go to ERR1.
  - WWAIT: latch `HWDATA` into `PWDATA`, then go to SETUP.
  - SETUP: `PSEL[slot]`=1, `PENABLE`=0, then go to ACCESS.
  - ACCESS: `PENABLE`=1. Stay while `PREADY`=0. On completion, take a newly sampled transfer directly (WWAIT, SETUP or ERR1), otherwise return to IDLE.
  - ERR1 always goes to ERR2. ERR2 behaves like an ACCESS completion.
- `PADDR` and `PWRITE` are registered at the sampling edge and held until the next sampled transfer.
- `PSEL` and `PENABLE` are registered and low outside SETUP/ACCESS.
- `HREADYout` is combinational from state:
  - 1 in IDLE and ERR2.
  - 0 in WWAIT, SETUP and ERR1.
  - In ACCESS it equals `PREADY`, or 1 without the macro.
- `HRESP` = 01 in ERR1 and ERR2, otherwise 00.
- `HRDATA` = `PRDATA` in the completing ACCESS cycle of a read, otherwise 0.
- No APB signal toggles for an erroring transfer.

## Timing
- Reset, sampled at a `HCLK` edge, puts the FSM in IDLE and clears `PSEL`, `PENABLE`, `PWRITE`, `PADDR` and `PWDATA` to 0. Resulting output values: `HREADYout`=1, `HRESP`=00, `HRDATA`=0.
- Reset mid-transfer drops `PSEL`/`PENABLE` at the same edge. The AHB master is reset alongside the bridge.
- Read: address at T0; SETUP at T1; ACCESS at T2. `HREADYout` is high at the end of T2, so there is 1 AHB wait state (T1).
- Write: address at T0; WWAIT at T1; SETUP at T2; ACCESS at T3. There are 2 wait states (T1, T2).
- Each `PREADY`=0 cycle in ACCESS adds one wait state.
- Back-to-back: a transfer sampled in the completing cycle at Tn starts SETUP or WWAIT at Tn+1, with no IDLE bubble.
- Error: ERR1 (`HREADYout`=0, `HRESP`=01), then ERR2 (`HREADYout`=1, `HRESP`=01). This is the two-cycle AHB error response.

## Configuration
- `AHB2APB_PREADY_EN` defined: the `PREADY` port exists and ACCESS stretches while it is low.
- Not defined: there is no `PREADY` port and ACCESS is always exactly one cycle.

## Test plan
- Reset: hold `HRESET`=1 for 2 cycles with random inputs. Required response: `HREADYout`=1, `HRESP`=00, `PSEL`=0, `PENABLE`=0, `HRDATA`=0.
- Write 0x8400_0010, data 0xDEAD_BEEF, `HSIZE`=010:
  - `PSEL`=0010 in T2–T3, `PENABLE` high only in T3.
  - `PADDR`=0x8400_0010, `PWDATA`=0xDEAD_BEEF, `PWRITE`=1.
  - `HREADYout` low in T1–T2.
- Read 0x8C00_0004 with `PRDATA`=0x1234_5678 and `PREADY` low for 2 cycles (macro on):
  - ACCESS lasts 3 cycles and `HREADYout` is low for 3 cycles.
  - `HRDATA`=0x1234_5678 in the completing cycle.
- Back-to-back: read to 0x8000_0000 immediately followed by a write to 0x8800_0000. The write's WWAIT follows ACCESS directly and `PSEL` goes 0001 → 0 → 0100.
- Unmapped address 0x9000_0000, and `HSIZE`=011 to 0x8000_0000:
  - `HRESP`=01 for 2 cycles, `HREADYout` 0 then 1.
  - `PSEL` stays 0.
- IDLE and BUSY `HTRANs`, and valid transfers with `HREADYin`=0: no APB activity, `HREADYout` stays 1.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave to APB master bridge: single transfers, wait-state insertion, two-cycle ERROR response.
// Optional macro AHB2APB_PREADY_EN adds the PREADY port so ACCESS can stretch; otherwise ACCESS is one cycle.
module ahb2apb_bridge #(
    parameter logic [3:0] BASE_NIB = 4'h8,
    parameter int         NSLV     = 4
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSELAPBif,
    input  logic [1:0]      HTRANs,
    input  logic            HWRITE,
    input  logic            HREADYin,
    input  logic [31:0]     HADDR,
    input  logic [2:0]      HSIZE,
    input  logic [31:0]     HWDATA,
    output logic            HREADYout,
    output logic [1:0]      HRESP,
    output logic [31:0]     HRDATA,
    output logic [NSLV-1:0] PSEL,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [31:0]     PADDR,
    output logic [31:0]     PWDATA,
`ifdef AHB2APB_PREADY_EN
    input  logic            PREADY,
`endif
    input  logic [31:0]     PRDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t     r_state;
    logic [1:0] r_slot;

    logic       w_pready;
    logic       w_valid;
    logic       w_mapped;
    logic       w_sample;
    logic       w_unused;

`ifdef AHB2APB_PREADY_EN
    assign w_pready = PREADY;
`else
    assign w_pready = 1'b1;
`endif

    // Only NONSEQ/SEQ matter, so the low HTRANs bit is intentionally ignored.
    assign w_unused = HTRANs[0];

    assign w_valid  = HSELAPBif & HREADYin & HTRANs[1];
    assign w_mapped = (HADDR[31:28] == BASE_NIB)
                   && (32'(HADDR[27:26]) < NSLV)
                   && (HSIZE <= 3'b010);
    assign w_sample = (r_state == S_IDLE) || (r_state == S_ERR2)
                   || ((r_state == S_ACCESS) && w_pready);

    function automatic logic [NSLV-1:0] slot_onehot(input logic [1:0] slot);
        logic [NSLV-1:0] oh;
        oh = '0;
        for (int i = 0; i < NSLV; i++) begin
            oh[i] = (slot == 2'(i));
        end
        return oh;
    endfunction

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (w_sample) begin
            // Completion edge doubles as the next address phase, so back-to-back transfers skip IDLE.
            PSEL    <= '0;
            PENABLE <= 1'b0;
            r_state <= S_IDLE;
            if (w_valid) begin
                if (w_mapped) begin
                    PADDR  <= HADDR;
                    PWRITE <= HWRITE;
                    r_slot <= HADDR[27:26];
                    if (HWRITE) begin
                        r_state <= S_WWAIT;
                    end else begin
                        r_state <= S_SETUP;
                        PSEL    <= slot_onehot(HADDR[27:26]);
                    end
                end else begin
                    r_state <= S_ERR1;
                end
            end
        end else begin
            case (r_state)
                S_WWAIT: begin
                    PWDATA  <= HWDATA;
                    PSEL    <= slot_onehot(r_slot);
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= S_ACCESS;
                end
                S_ERR1: begin
                    r_state <= S_ERR2;
                end
                default: begin
                    // ACCESS stalled on PREADY: hold everything.
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves HREADYout unassigned (no latch).
        HREADYout = 1'b0;
        case (r_state)
            S_IDLE, S_ERR2: HREADYout = 1'b1;
            S_ACCESS:       HREADYout = w_pready;
            default:        HREADYout = 1'b0;
        endcase
    end

    assign HRESP  = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA = ((r_state == S_ACCESS) && !PWRITE && w_pready) ? PRDATA : '0;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: stimulus pushes expected completions, a negedge monitor checks them.
// Works with or without AHB2APB_PREADY_EN.
module tb_ahb2apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSELAPBif = 1'b0;
    logic [1:0]  HTRANs = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADYin = 1'b1;
    logic [31:0] HADDR = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADYout;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY = 1'b1;
    logic [31:0] PRDATA = '0;
    logic        pready_eff;

`ifdef AHB2APB_PREADY_EN
    assign pready_eff = PREADY;
    localparam int RD_STALL_WAITS = 3;
`else
    assign pready_eff = 1'b1;
    localparam int RD_STALL_WAITS = 1;
`endif

    ahb2apb_bridge dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSELAPBif (HSELAPBif),
        .HTRANs    (HTRANs),
        .HWRITE    (HWRITE),
        .HREADYin  (HREADYin),
        .HADDR     (HADDR),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYout (HREADYout),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
`ifdef AHB2APB_PREADY_EN
        .PREADY    (PREADY),
`endif
        .PRDATA    (PRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          is_err;
        logic [3:0]  psel;
        logic [31:0] paddr;
        bit          pwrite;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_cnt = 0;
    int   apb_cycles = 0;
    int   stall_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave model: hold PREADY low for stall_req cycles at the start of each ACCESS.
    initial begin
        int stall_left;
        stall_left = 0;
        forever begin
            @(posedge HCLK);
            #1;
            if (!PENABLE) stall_left = stall_req;
            if (PENABLE && stall_left > 0) begin
                PREADY = 1'b0;
                stall_left--;
            end else begin
                PREADY = 1'b1;
            end
        end
    end

    // Monitor: count wait states and compare each completed transfer against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                wait_cnt = 0;
            end else begin
                if (PSEL != 4'b0) apb_cycles++;
                if ((PSEL != 4'b0 && PENABLE && pready_eff) || (HRESP == 2'b01 && HREADYout)) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("resp_kind", 32'(HRESP == 2'b01), 32'(e.is_err));
                        check("wait_states", wait_cnt, e.waits);
                        if (e.is_err) begin
                            check("err_psel", PSEL, 4'b0);
                        end else begin
                            check("psel", PSEL, e.psel);
                            check("paddr", PADDR, e.paddr);
                            check("pwrite", PWRITE, e.pwrite);
                            if (e.pwrite) check("pwdata", PWDATA, e.data);
                            else          check("hrdata", HRDATA, e.data);
                        end
                    end
                    wait_cnt = 0;
                end else if (!HREADYout) begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        HSELAPBif = 1'b1;
        HTRANs    = 2'b10;
        HWRITE    = wr;
        HADDR     = a;
        HSIZE     = sz;
    endtask

    task automatic idle_bus();
        HSELAPBif = 1'b0;
        HTRANs    = 2'b00;
    endtask

    // Waits (bounded) for HREADYout high, then steps just past the completing edge.
    task automatic wait_ready();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge HCLK);
            seen = HREADYout;
        end
        check("ready_timeout", seen, 1'b1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        addr_phase(wr, a, sz);
        @(posedge HCLK);
        #1;
        idle_bus();
        HWDATA = wd;
        wait_ready();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        logic [3:0] idle_vec [5];

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            HSELAPBif = 1'($urandom);
            HTRANs    = 2'($urandom);
            HWRITE    = 1'($urandom);
            HREADYin  = 1'($urandom);
            HADDR     = $urandom;
            HSIZE     = 3'($urandom);
            HWDATA    = $urandom;
            PRDATA    = $urandom;
            @(posedge HCLK);
            #1;
        end
        @(negedge HCLK);
        check("rst_hready", HREADYout, 1'b1);
        check("rst_hresp", HRESP, 2'b00);
        check("rst_psel", PSEL, 4'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        @(posedge HCLK);
        #1;
        idle_bus();
        HREADYin = 1'b1;
        HWDATA   = '0;
        PRDATA   = '0;
        HRESET   = 1'b0;
        @(posedge HCLK);
        #1;

        // Write 0x8400_0010: cycle-by-cycle APB phase checks.
        sb_q.push_back('{1'b0, 4'b0010, 32'h8400_0010, 1'b1, 32'hDEAD_BEEF, 2});
        addr_phase(1'b1, 32'h8400_0010, 3'b010);
        @(posedge HCLK);
        #1;
        idle_bus();
        HWDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        check("wr_t1_psel", PSEL, 4'b0);
        check("wr_t1_hready", HREADYout, 1'b0);
        @(posedge HCLK);
        #1;
        HWDATA = 32'h5555_AAAA;
        @(negedge HCLK);
        check("wr_t2_psel", PSEL, 4'b0010);
        check("wr_t2_penable", PENABLE, 1'b0);
        check("wr_t2_hready", HREADYout, 1'b0);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("wr_t3_penable", PENABLE, 1'b1);
        check("wr_t3_hready", HREADYout, 1'b1);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        check("wr_t4_psel", PSEL, 4'b0);
        check("wr_t4_penable", PENABLE, 1'b0);
        @(posedge HCLK);
        #1;

        // Read 0x8C00_0004 with two PREADY stall cycles (only effective with the macro).
        stall_req = 2;
        PRDATA    = 32'h1234_5678;
        sb_q.push_back('{1'b0, 4'b1000, 32'h8C00_0004, 1'b0, 32'h1234_5678, RD_STALL_WAITS});
        xfer(1'b0, 32'h8C00_0004, 3'b010, 32'h0);
        stall_req = 0;
        check("rd_idle_hrdata", HRDATA, 32'h0);

        // Back-to-back: read slot 0 then write slot 2 with no IDLE bubble.
        PRDATA = 32'hCAFE_0001;
        sb_q.push_back('{1'b0, 4'b0001, 32'h8000_0000, 1'b0, 32'hCAFE_0001, 1});
        sb_q.push_back('{1'b0, 4'b0100, 32'h8800_0000, 1'b1, 32'h0BAD_F00D, 2});
        addr_phase(1'b0, 32'h8000_0000, 3'b010);
        @(posedge HCLK);
        #1;
        addr_phase(1'b1, 32'h8800_0000, 3'b010);
        wait_ready();
        idle_bus();
        HWDATA = 32'h0BAD_F00D;
        @(negedge HCLK);
        check("b2b_wwait_psel", PSEL, 4'b0);
        check("b2b_wwait_hready", HREADYout, 1'b0);
        wait_ready();

        // Error responses: unmapped base, then oversized transfer.
        a0 = apb_cycles;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{1'b1, 4'b0, 32'h0, 1'b0, 32'h0, 1});
            if (i == 0) addr_phase(1'b0, 32'h9000_0000, 3'b010);
            else        addr_phase(1'b1, 32'h8000_0000, 3'b011);
            @(posedge HCLK);
            #1;
            idle_bus();
            @(negedge HCLK);
            check("err1_hresp", HRESP, 2'b01);
            check("err1_hready", HREADYout, 1'b0);
            wait_ready();
        end
        check("err_no_apb", apb_cycles, a0);
        check("err_paddr_held", PADDR, 32'h8800_0000);
        check("err_pwrite_held", PWRITE, 1'b1);

        // No-action patterns: {HSELAPBif, HTRANs, HREADYin}.
        idle_vec[0] = 4'b1_00_1;
        idle_vec[1] = 4'b1_01_1;
        idle_vec[2] = 4'b1_10_0;
        idle_vec[3] = 4'b0_10_1;
        idle_vec[4] = 4'b1_11_0;
        a0 = apb_cycles;
        for (int i = 0; i < 5; i++) begin
            HSELAPBif = idle_vec[i][3];
            HTRANs    = idle_vec[i][2:1];
            HREADYin  = idle_vec[i][0];
            HWRITE    = 1'b0;
            HADDR     = 32'h8000_0000;
            HSIZE     = 3'b010;
            @(negedge HCLK);
            check("noop_hready", HREADYout, 1'b1);
            check("noop_hresp", HRESP, 2'b00);
            @(posedge HCLK);
            #1;
        end
        idle_bus();
        HREADYin = 1'b1;
        @(negedge HCLK);
        check("noop_last_hready", HREADYout, 1'b1);
        check("noop_psel", PSEL, 4'b0);
        check("noop_no_apb", apb_cycles, a0);
        @(posedge HCLK);
        #1;

        // Reset during SETUP drops PSEL at the reset edge.
        addr_phase(1'b0, 32'h8400_0000, 3'b010);
        @(posedge HCLK);
        #1;
        idle_bus();
        HRESET = 1'b1;
        @(negedge HCLK);
        check("mid_setup_psel", PSEL, 4'b0010);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("mid_rst_psel", PSEL, 4'b0);
        check("mid_rst_penable", PENABLE, 1'b0);
        check("mid_rst_hready", HREADYout, 1'b1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
